// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART receiver for the USB-RS232 bridge. Synchronises the serial
//             input, detects the start bit and samples 8N1 frames at mid-bit.
//             Each received byte comes with a one-cycle valid strobe. Framing
//             and parity errors are reported as one-cycle strobes.
//  Options  : define UART_RX_PARITY_EN for 8E1 frames (even parity bit
//             between the last data bit and the stop bit).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       user_clock,
  input  logic       rst,
  input  logic       usb_rs232_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_busy
);

  // Half a bit period positions the first sample in the middle of the start
  // bit. Every later sample is one full bit period after the previous one.
  localparam logic [15:0] c_HALF_BIT    = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] c_FULL_BIT_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  logic        rxd_meta_q;
  logic        rxd_s_q;
  state_t      state_q,  state_d;
  logic [15:0] baud_q,   baud_d;
  logic [2:0]  bit_q,    bit_d;
  logic [7:0]  shift_q,  shift_d;
  logic [7:0]  data_q,   data_d;
  logic        valid_q,  valid_d;
  logic        ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        perr_q,    perr_d;
`endif

  logic        w_sample;

  // The baud counter reaching zero marks a sample point in every timed state.
  assign w_sample = (baud_q == 16'd0);

  // Two-flop synchroniser; resets to the idle (high) line level so that a
  // reset never looks like a start bit by itself.
  always_ff @(posedge user_clock) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= usb_rs232_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // State, timing and result registers.
  always_ff @(posedge user_clock) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic: walks the frame bit by bit, sampling at mid-bit and
  // raising exactly one result strobe per completed frame.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s_q) begin
          state_d = ST_START;
          baud_d  = c_HALF_BIT;
          bit_d   = 3'd0;
        end
      end

      ST_START: begin
        if (w_sample) begin
          if (!rxd_s_q) begin
            state_d = ST_DATA;
            baud_d  = c_FULL_BIT_M1;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      ST_DATA: begin
        if (w_sample) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          baud_d  = c_FULL_BIT_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_sample) begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          par_bad_d = rxd_s_q ^ (^shift_q);
          baud_d    = c_FULL_BIT_M1;
          state_d   = ST_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif

      ST_STOP: begin
        if (w_sample) begin
          baud_d = c_FULL_BIT_M1;
          if (rxd_s_q) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            // A framing error outranks a parity error, and a line stuck low
            // must not restart reception until it has gone high again.
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      ST_WAIT_HIGH: begin
        if (rxd_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif
  assign rx_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Frames are generated at line
//             level; the expected strobe kind, byte and cycle for each frame
//             come from the frame contents and mid-bit timing arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int N = 434;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Cycles from the first clock edge that sees the start bit on the pin to
  // the cycle the strobe is visible: 2 synchroniser edges, 1 edge to enter
  // START, then stop sample at H+(9+PAR)*N and a registered strobe.
  localparam int STROBE_LAT = 3 + H + (9 + PAR) * N;
  localparam int FRAME_CYC  = (10 + PAR) * N;

  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;
  localparam int K_MULTI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .user_clock   (clk),
    .rst          (rst),
    .usb_rs232_rxd(rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_busy      (rx_busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  int         edge_cnt    = 0;
  int         busy_cycles = 0;
  int         checks      = 0;
  int         errors      = 0;
  logic [7:0] last_good   = 8'h00;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Log every strobe seen, with the byte on rx_data and the cycle number.
  always @(negedge clk) begin
    int  n;
    ev_t e;
    if (rx_busy === 1'b1) busy_cycles++;
    n = int'(rx_valid === 1'b1) + int'(rx_frame_err === 1'b1) + int'(rx_parity_err === 1'b1);
    if (n != 0) begin
      if (n > 1)                    e.kind = K_MULTI;
      else if (rx_valid === 1'b1)   e.kind = K_VALID;
      else if (rx_frame_err === 1'b1) e.kind = K_FERR;
      else                          e.kind = K_PERR;
      e.data = rx_data;
      e.cyc  = edge_cnt;
      got_q.push_back(e);
    end
  end

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int bits);
    rxd = 1'b1;
    repeat (bits * N) @(negedge clk);
  endtask

  // Drive one frame starting at a negedge and record what it must produce.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    ev_t e;
    e.cyc = edge_cnt + 1 + STROBE_LAT;
    if (!stop)                         e.kind = K_FERR;
    else if (PAR == 1 && par != ^d)    e.kind = K_PERR;
    else                               e.kind = K_VALID;
    if (e.kind == K_VALID) last_good = d;
    e.data = last_good;
    exp_q.push_back(e);
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (N) @(negedge clk);
    end
    if (PAR == 1) begin
      rxd = par;
      repeat (N) @(negedge clk);
    end
    rxd = stop;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset rx_data: got %02h, required 00", rx_data);
    end
    checks++;
    if ({rx_valid, rx_frame_err, rx_parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset strobes: got %b, required 000", {rx_valid, rx_frame_err, rx_parity_err});
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL reset rx_busy: got %b, required 0", rx_busy);
    end
    rst = 1'b1;
    last_good = 8'h00;
    clear_logs();
    idle(1);
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL reset idle strobes: got %0d, required 0", got_q.size());
    end
  endtask

  task automatic test_single_a();
    clear_logs();
    send_frame(8'h41, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL single_a count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL single_a event %0d: missing, required kind %0d", i, exp_q[i].kind);
      end else if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL single_a event %0d: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                 i, got_q[i].kind, got_q[i].data, got_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
    if (rx_data !== 8'h41) begin
      errors++; $display("FAIL single_a rx_data: got %02h, required 41", rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [3];
    msg[0] = 8'h4C; msg[1] = 8'h45; msg[2] = 8'h58;
    clear_logs();
    for (int i = 0; i < 3; i++) send_frame(msg[i], 1'b1, ^msg[i]);
    idle(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL back_to_back count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL back_to_back event %0d: missing, required kind %0d", i, exp_q[i].kind);
      end else if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL back_to_back event %0d: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                 i, got_q[i].kind, got_q[i].data, got_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL back_to_back spacing %0d: strobe missing, required spacing %0d", i, FRAME_CYC);
      end else if (got_q[i].cyc - got_q[i-1].cyc !== FRAME_CYC) begin
        errors++; $display("FAIL back_to_back spacing %0d: got %0d, required %0d", i, got_q[i].cyc - got_q[i-1].cyc, FRAME_CYC);
      end
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    busy_cycles = 0;
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    idle(2);
    checks++;
    if (busy_cycles !== H + 1) begin
      errors++; $display("FAIL glitch busy cycles: got %0d, required %0d", busy_cycles, H + 1);
    end
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL glitch strobes: got %0d, required 0", got_q.size());
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] prev;
    prev = last_good;
    clear_logs();
    send_frame(8'h55, 1'b0, ^8'h55);
    rxd = 1'b0;
    repeat (3 * N) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL frame_err busy while low: got %b, required 1", rx_busy);
    end
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL frame_err busy after high: got %b, required 0", rx_busy);
    end
    idle(1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL frame_err count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL frame_err event %0d: missing, required kind %0d", i, exp_q[i].kind);
      end else if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL frame_err event %0d: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                 i, got_q[i].kind, got_q[i].data, got_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
    if (rx_data !== prev) begin
      errors++; $display("FAIL frame_err rx_data: got %02h, required %02h", rx_data, prev);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h41;
    clear_logs();
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (N) @(negedge clk);
    end
    rxd = d[4];
    repeat (H) @(negedge clk);
    // Both ends reset together: the line returns to idle with the reset.
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    last_good = 8'h00;
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid busy: got %b, required 0", rx_busy);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_mid rx_data: got %02h, required 00", rx_data);
    end
    idle(3);
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL reset_mid aborted strobes: got %0d, required 0", got_q.size());
    end
    clear_logs();
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL reset_mid count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL reset_mid event %0d: missing, required kind %0d", i, exp_q[i].kind);
      end else if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL reset_mid event %0d: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                 i, got_q[i].kind, got_q[i].data, got_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    logic       par;
    clear_logs();
    for (int f = 0; f < 4; f++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = ($urandom_range(0, 2) == 0) ? ~(^d) : ^d;
      send_frame(d, stop, par);
      if (!stop) idle(1);
      else       idle(int'($urandom_range(0, 1)));
    end
    idle(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL random count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL random event %0d: missing, required kind %0d", i, exp_q[i].kind);
      end else if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL random event %0d: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                 i, got_q[i].kind, got_q[i].data, got_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_logs();
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b1);
    idle(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL parity count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++; $display("FAIL parity event %0d: missing, required kind %0d", i, exp_q[i].kind);
      end else if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL parity event %0d: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                 i, got_q[i].kind, got_q[i].data, got_q[i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    idle(1);
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the USB-RS232 bridge: the receive side of the UART link whose transmitter drives `usb_rs232_txd`. It synchronises `usb_rs232_rxd` to `user_clock` and detects the start bit. It samples 8N1 frames, optionally with even parity, at mid-bit and presents each received byte with a one-cycle valid strobe. It sits beside the transmitter in `main`, sharing its clock, reset and baud divisor.

## Interface
- `CLKS_PER_BIT`, 434, `user_clock` cycles per bit (50 MHz / 115200 baud); legal range 8..65535.
- `user_clock`  in  1  system clock, 50 MHz, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on `user_clock` rising edge.
- `usb_rs232_rxd`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  last correctly received byte, LSB = first data bit.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated this cycle.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without `UART_RX_PARITY_EN`).
- `rx_busy`  out  1  high from start-bit detection until the frame completes or is aborted.

## Operation
- Input is registered through a 2-flop synchroniser (`rxd_s`); both flops reset to 1. A 2-cycle input latency is inherent.
- State machine:
  - IDLE: `rxd_s`==0 -> START, bit counter cleared.
  - START: after H = CLKS_PER_BIT/2 (integer divide) cycles, sample. 0 -> DATA. 1 -> false start, back to IDLE with no strobe.
  - DATA: every CLKS_PER_BIT cycles sample into a shift register, LSB first. After the 8th bit -> PARITY if enabled, otherwise STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample; compare with XOR of the 8 data bits (even parity). The result is held until stop.
  - STOP: after CLKS_PER_BIT cycles, sample. The outcome is:
    - 1 with parity ok: `rx_data` loaded, `rx_valid` pulsed.
    - 1 with parity bad: `rx_parity_err` pulsed, `rx_data` unchanged.
    - 0: `rx_frame_err` pulsed, `rx_data` unchanged. A frame error takes precedence; `rx_parity_err` is not also pulsed.
  - After stop sample 1 -> IDLE. After stop sample 0 -> WAIT_HIGH.
  - WAIT_HIGH: stays until `rxd_s`==1, then IDLE. A held-low line (break) yields exactly one `rx_frame_err`.
- Baud counter is 16 bits, counts down, and reloads on every sample.
- `rx_busy` = state != IDLE (WAIT_HIGH counts as busy).
- No receive buffering: the consumer must capture `rx_data` on `rx_valid`. `rx_data` is stable until the next `rx_valid`.

## Timing
- Reset (`rst`==0 at a clock edge) has these values: `rx_data`=8'h00, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0, `rx_busy`=0, state IDLE, synchroniser=1.
- Reset asserted mid-frame aborts immediately with no strobe. Reception restarts on the next falling edge after release.
- Let cycle 0 be the first cycle state=START. The sample points are:
  - start bit at cycle H;
  - data bit k (k=0..7) at H+(k+1)·N, where N = CLKS_PER_BIT;
  - parity (if enabled) at H+9N;
  - stop at H+9N, or H+10N with parity.
- Strobes are registered, high in the cycle after the stop sample. For N=434: `rx_valid` at cycle 4124 (no parity).
- State is IDLE in the cycle of the strobe, so a start bit immediately following the stop bit's mid-point is accepted. Back-to-back frames need no extra idle time.
- Strobes are mutually exclusive and never last more than one cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1. The PARITY state is present, and `rx_parity_err` is driven.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1. The PARITY state and its logic are not compiled, and `rx_parity_err` is constant 0.

## Test plan
- N=434, `user_clock` 20 ns period, 8N1 frame 0x41 ('A') at 8680 ns/bit -> single `rx_valid`, `rx_data`=8'h41, no error strobes.
- Frames 'L','E','X' (0x4C, 0x45, 0x58) back-to-back with zero idle bits -> three `rx_valid` pulses exactly 10·N cycles apart, with the correct bytes.
- 1 µs low glitch on idle line -> `rx_busy` high for H+1 cycles, then IDLE, with no strobe.
- Frame 0x55 with the stop bit forced 0, then the line held low for 3 bit times -> exactly one `rx_frame_err`, `rx_data` keeps its previous value, and `rx_busy` stays high until the line returns high.
- `rst` low for 1 cycle during data bit 4 of 0x41, then a clean frame 0x5A -> no strobe for the aborted frame, then `rx_valid` with 8'h5A.
- With `UART_RX_PARITY_EN`: 0x41 with parity 0 -> `rx_valid`, 8'h41. 0x41 with parity 1 -> `rx_parity_err` pulse and no `rx_valid`.
